// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - serial wide adder, one 4-bit nibble per cycle, valid/ready in and out
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 In_valid,
  output logic                 In_ready,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 Cin,
  output logic                 Out_valid,
  input  logic                 Out_ready,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 Carry,
  output logic                 Overflow,
  output logic                 Busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;
  logic [W-1:0]  work_sum;
  logic [W-1:0]  work_next;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          ovf_q;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [4:0]    nib_res;
  logic [3:0]    low3_res;
  logic          last_nib;

  // Current nibble slice; the full 5-bit result is kept so the carry is never lost.
  always_comb begin
    nib_a     = a_reg[{idx, 2'b00} +: 4];
    nib_b     = b_reg[{idx, 2'b00} +: 4];
    nib_res   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_reg};
    low3_res  = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, carry_reg};
    last_nib  = (idx == LAST_IDX);
    work_next = work_sum;
    work_next[{idx, 2'b00} +: 4] = nib_res[3:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (In_valid) state_next = RUN;
      RUN:     if (last_nib) state_next = DONE;
      DONE:    if (Out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      work_sum  <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (In_valid) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Cin;
            idx       <= '0;
            work_sum  <= '0;
          end
        end
        RUN: begin
          work_sum  <= work_next;
          carry_reg <= nib_res[4];
          if (last_nib) begin
            // Overflow compares the carry into the sign bit with the carry out of it.
            sum_q   <= work_next;
            carry_q <= nib_res[4];
            ovf_q   <= nib_res[4] ^ low3_res[3];
            idx     <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign In_ready  = (state == IDLE);
  assign Busy      = (state == RUN);
  assign Out_valid = (state == DONE);
  assign Sum       = sum_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;

endmodule
